// File: rtl/fluid_board_soc_shared_mem_pkg.sv
// Shared definitions for the shared-RAM block streamer.
// FSM states, completion status codes and default geometry.
package fluid_board_soc_shared_mem_pkg;

    localparam int DEF_ADDR_W  = 14;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_MAX_LEN = 16384;

    localparam logic [1:0] STAT_OK     = 2'b00;
    localparam logic [1:0] STAT_ABORT  = 2'b01;
    localparam logic [1:0] STAT_BADLEN = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_FINISH
    } state_t;

endpackage

// File: rtl/fluid_board_soc_shared_mem_streamer_if.sv
// RAM slave-port bus plus the source and sink streams.
// master = streamer side, slave = RAM/stream-peer side.
interface fluid_board_soc_shared_mem_streamer_if
    import fluid_board_soc_shared_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] m_address;
    logic [1:0]        m_byteenable;
    logic              m_chipselect;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic              m_clken;
    logic [DATA_W-1:0] m_readdata;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] snk_data;
    logic              snk_valid;
    logic              snk_ready;

    modport master (
        output m_address, m_byteenable, m_chipselect,
        output m_write, m_writedata, m_clken,
        input  m_readdata,
        output src_data, src_valid,
        input  src_ready,
        input  snk_data, snk_valid,
        output snk_ready
    );

    modport slave (
        input  m_address, m_byteenable, m_chipselect,
        input  m_write, m_writedata, m_clken,
        output m_readdata,
        input  src_data, src_valid,
        output src_ready,
        output snk_data, snk_valid,
        input  snk_ready
    );
endinterface

// File: rtl/fluid_board_soc_skid_fifo2.sv
// Two-entry FIFO on the RAM read-return path.
// flush empties it in one cycle and wins over a push.
module fluid_board_soc_skid_fifo2 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;

    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_q;
    assign count_o = count_q;

    // next occupancy and entry contents
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) head_d = push_data_i;
                    else                 tail_d = push_data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = push_data_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // entry and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/fluid_board_soc_shared_mem_streamer.sv
// Block mover between the shared RAM second port and local streams.
// Reads land one cycle after issue; writes complete when presented.
module fluid_board_soc_shared_mem_streamer
    import fluid_board_soc_shared_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    fluid_board_soc_shared_mem_streamer_if.master bus
);
    localparam int LEN_W = ADDR_W + 1;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        status_q, status_d;
    logic              ab_q, ab_d;
    logic              inflight_q;
    logic              wr_pend_q;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              clken_q;

    logic              issue, accept, pop, push, flush, snk_rdy;
    logic              f_valid, drain_done;
    logic [DATA_W-1:0] f_data;
    logic [1:0]        f_count;
    logic [2:0]        occ;

    assign pop   = f_valid & bus.src_ready;
    assign occ   = {1'b0, f_count} + {2'b00, inflight_q}
                 - {2'b00, pop};
    assign issue = (state_q == S_READ) && (cnt_q != '0)
                 && (occ < 3'd2);

    assign snk_rdy = (state_q == S_WRITE) && (cnt_q != '0);
    assign accept  = snk_rdy & bus.snk_valid;

    // last word leaves the FIFO this cycle with nothing in flight
    assign drain_done = !inflight_q
                      && ((f_count == 2'd0)
                      || ((f_count == 2'd1) && pop));

    // data returning after an abort is dropped
    assign push = inflight_q & ~ab_q & ~flush;

    fluid_board_soc_skid_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (bus.m_readdata),
        .pop_i       (pop),
        .valid_o     (f_valid),
        .data_o      (f_data),
        .count_o     (f_count)
    );

    assign busy   = (state_q == S_CHECK) || (state_q == S_READ)
                 || (state_q == S_DRAIN) || (state_q == S_WRITE);
    assign done   = (state_q == S_FINISH);
    assign status = status_q;

    assign bus.m_address    = addr_q;
    assign bus.m_byteenable = 2'b11;
    assign bus.m_chipselect = issue | wr_pend_q;
    assign bus.m_write      = wr_pend_q;
    assign bus.m_writedata  = wr_data_q;
    assign bus.m_clken      = clken_q;
    assign bus.src_data     = f_data;
    assign bus.src_valid    = f_valid;
    assign bus.snk_ready    = snk_rdy;

    // next-state, counters and abort decisions
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        status_d  = status_q;
        ab_d      = ab_q;
        flush     = 1'b0;
        wr_data_d = accept ? bus.snk_data : wr_data_q;
        if (issue || wr_pend_q) addr_d = addr_q + ADDR_W'(1);
        if (issue || accept)    cnt_d  = cnt_q - LEN_W'(1);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dir_d    = dir;
                    addr_d   = base_addr;
                    cnt_d    = length;
                    status_d = STAT_OK;
                    ab_d     = 1'b0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cnt_q == '0) begin
                    status_d = STAT_OK;
                    state_d  = S_FINISH;
                end else if (cnt_q > LEN_W'(MAX_LEN)) begin
                    status_d = STAT_BADLEN;
                    state_d  = S_FINISH;
                end else begin
                    state_d = dir_q ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    flush   = 1'b1;
                    ab_d    = 1'b1;
                    state_d = S_DRAIN;
                end else if (issue && (cnt_q == LEN_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ab_q) begin
                    status_d = STAT_ABORT;
                    state_d  = S_FINISH;
                end else if (drain_done) begin
                    status_d = STAT_OK;
                    state_d  = S_FINISH;
                end else if (abort) begin
                    flush = 1'b1;
                    ab_d  = 1'b1;
                end
            end
            S_WRITE: begin
                if (cnt_q == '0) begin
                    status_d = STAT_OK;
                    state_d  = S_FINISH;
                end else if (abort
                    && !((cnt_q == LEN_W'(1)) && accept)) begin
                    flush   = 1'b1;
                    ab_d    = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            status_q   <= STAT_OK;
            ab_q       <= 1'b0;
            inflight_q <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_data_q  <= '0;
            clken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            ab_q       <= ab_d;
            inflight_q <= issue;
            wr_pend_q  <= accept;
            wr_data_q  <= wr_data_d;
            clken_q    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fluid_board_soc_shared_mem_streamer.sv
// Directed bench for the shared-RAM streamer.
// RAM model: one-cycle read latency, preloaded with i ^ 16'hA5A5.
module tb_fluid_board_soc_shared_mem_streamer;
    import fluid_board_soc_shared_mem_pkg::*;

    localparam int AW = 14;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          dir;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          abort;
    logic          busy;
    logic          done;
    logic [1:0]    status;

    fluid_board_soc_shared_mem_streamer_if #(
        .ADDR_W(AW), .DATA_W(DW)) bus ();

    fluid_board_soc_shared_mem_streamer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dir       (dir),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .status    (status),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:16383];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_cs = 0, n_wr = 0, n_rd = 0, n_pop = 0, max_out = 0;
    int done_cnt = 0, start_cyc = 0, done_cyc = 0;
    int last_pop_cyc = 0;
    logic [1:0] done_stat = 2'b00;
    logic [DW-1:0] rx_q [$];
    logic [AW-1:0] ra_q [$];

    initial begin
        for (int i = 0; i < 16384; i++)
            mem[i] = 16'(i) ^ 16'hA5A5;
    end

    always @(posedge clk) begin
        if (bus.m_chipselect) begin
            n_cs++;
            if (bus.m_write) begin
                mem[bus.m_address] = bus.m_writedata;
                n_wr++;
            end else begin
                bus.m_readdata <= mem[bus.m_address];
                ra_q.push_back(bus.m_address);
                n_rd++;
            end
        end
        if (bus.src_valid && bus.src_ready) begin
            rx_q.push_back(bus.src_data);
            n_pop++;
            last_pop_cyc = cyc;
        end
        if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
        if (start) start_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_stat = status;
        end
        cyc++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_cs = 0; n_wr = 0; n_rd = 0; n_pop = 0; max_out = 0;
        rx_q.delete();
        ra_q.delete();
    endtask

    task automatic go(input logic d, input logic [AW-1:0] ba,
                      input logic [AW:0] len);
        @(posedge clk); #1;
        start = 1'b1; dir = d; base_addr = ba; length = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget);
        int k = 0;
        while (done_cnt == prev && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", (done_cnt > prev) ? 1 : 0, 1);
    endtask

    task automatic chk_rx(input string tag, input int i,
                          input logic [DW-1:0] exp);
        logic [31:0] obs;
        obs = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hxxxxxxxx;
        chk(tag, obs, 32'(exp));
    endtask

    int p;
    int k;
    logic acc;
    logic [AW-1:0] ea;

    initial begin
        reset_n = 1'b0; start = 1'b0; dir = 1'b0;
        base_addr = '0; length = '0; abort = 1'b0;
        bus.src_ready = 1'b0; bus.snk_valid = 1'b0;
        bus.snk_data = '0;
        #12;
        chk("rst_clken", bus.m_clken, 0);
        chk("rst_be", bus.m_byteenable, 2'b11);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", bus.m_chipselect, 0);
        chk("rst_src_valid", bus.src_valid, 0);
        chk("rst_snk_ready", bus.snk_ready, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("clken_after_rst", bus.m_clken, 1);

        // read 8 words from 100 at full rate
        clr(); bus.src_ready = 1'b1; p = done_cnt;
        go(1'b0, 14'd100, 15'd8);
        @(negedge clk);
        chk("rd1_busy_after_start", busy, 1);
        wait_done(p, 40);
        chk("rd1_beats", rx_q.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_rx("rd1_data", i, 16'(100 + i) ^ 16'hA5A5);
        chk("rd1_status", done_stat, STAT_OK);
        chk("rd1_latency", done_cyc - start_cyc, 12);
        chk("rd1_done_after_pop", done_cyc - last_pop_cyc, 1);
        chk("rd1_cs", n_cs, 8);
        chk("rd1_busy_end", busy, 0);
        chk("rd1_done_once", done_cnt - p, 1);

        // wrapping read with stalling sink
        clr(); bus.src_ready = 1'b0; p = done_cnt;
        go(1'b0, 14'd16380, 15'd6);
        k = 0;
        while (done_cnt == p && k < 100) begin
            @(posedge clk); #1;
            bus.src_ready = ~bus.src_ready;
            k++;
        end
        chk("rd2_done_seen", (done_cnt > p) ? 1 : 0, 1);
        chk("rd2_beats", rx_q.size(), 6);
        chk("rd2_reads", n_rd, 6);
        chk("rd2_outstanding_le2", (max_out <= 2) ? 1 : 0, 1);
        for (int i = 0; i < 6; i++) begin
            ea = 14'(16380 + i);
            chk_rx("rd2_data", i, 16'(ea) ^ 16'hA5A5);
            chk("rd2_addr", (i < ra_q.size()) ? 32'(ra_q[i])
                : 32'hxxxxxxxx, 32'(ea));
        end
        chk("rd2_status", done_stat, STAT_OK);

        // wrapping write of 1,2,3 at 16383
        clr(); bus.src_ready = 1'b0; p = done_cnt;
        bus.snk_data = 16'd1; bus.snk_valid = 1'b1;
        go(1'b1, 14'd16383, 15'd3);
        k = 0;
        while (done_cnt == p && k < 50) begin
            @(negedge clk);
            acc = bus.snk_ready && bus.snk_valid;
            @(posedge clk); #1;
            if (acc) begin
                if (bus.snk_data == 16'd3) bus.snk_valid = 1'b0;
                bus.snk_data = bus.snk_data + 16'd1;
            end
            k++;
        end
        chk("wr_done_seen", (done_cnt > p) ? 1 : 0, 1);
        chk("wr_mem16383", mem[16383], 1);
        chk("wr_mem0", mem[0], 2);
        chk("wr_mem1", mem[1], 3);
        chk("wr_mem2_untouched", mem[2], 16'h0002 ^ 16'hA5A5);
        chk("wr_strobes", n_wr, 3);
        chk("wr_cs", n_cs, 3);
        chk("wr_status", done_stat, STAT_OK);
        bus.snk_valid = 1'b0;

        // zero length
        clr(); p = done_cnt;
        go(1'b0, 14'd50, 15'd0);
        wait_done(p, 10);
        chk("len0_latency", done_cyc - start_cyc, 2);
        chk("len0_status", done_stat, STAT_OK);
        chk("len0_cs", n_cs, 0);

        // over-long length
        clr(); p = done_cnt;
        go(1'b0, 14'd50, 15'd16385);
        wait_done(p, 10);
        chk("badlen_latency", done_cyc - start_cyc, 2);
        chk("badlen_status", done_stat, STAT_BADLEN);
        chk("badlen_cs", n_cs, 0);

        // abort a stalled read
        clr(); bus.src_ready = 1'b0; p = done_cnt;
        go(1'b0, 14'd300, 15'd20);
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("ab_src_valid_pre", bus.src_valid, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("ab_src_valid_post", bus.src_valid, 0);
        wait_done(p, 10);
        chk("ab_status", done_stat, STAT_ABORT);
        chk("ab_latency", done_cyc - start_cyc, 6);
        chk("ab_reads", n_rd, 2);
        chk("ab_pops", n_pop, 0);
        chk("ab_busy_end", busy, 0);

        // reset in the middle of a write
        clr(); bus.snk_data = 16'h1234; bus.snk_valid = 1'b1;
        go(1'b1, 14'd200, 15'd10);
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("mid_write_active", bus.m_write, 1);
        p = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_status", status, STAT_OK);
        chk("mrst_cs", bus.m_chipselect, 0);
        chk("mrst_write", bus.m_write, 0);
        chk("mrst_wdata", bus.m_writedata, 0);
        chk("mrst_addr", bus.m_address, 0);
        chk("mrst_clken", bus.m_clken, 0);
        chk("mrst_be", bus.m_byteenable, 2'b11);
        chk("mrst_snk_ready", bus.snk_ready, 0);
        chk("mrst_src_valid", bus.src_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        bus.snk_valid = 1'b0;
        reset_n = 1'b1;
        chk("mrst_no_done", done_cnt - p, 0);
        @(posedge clk); #1;
        chk("mrst_clken_back", bus.m_clken, 1);

        // single word read after reset
        clr(); bus.src_ready = 1'b1; p = done_cnt;
        go(1'b0, 14'd5, 15'd1);
        wait_done(p, 20);
        chk("post_beats", rx_q.size(), 1);
        chk_rx("post_data", 0, 16'h0005 ^ 16'hA5A5);
        chk("post_status", done_stat, STAT_OK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fluid_board_soc_shared_mem_streamer.md
Name: fluid_board_soc_shared_mem_streamer

Overview:
- Initiator-side engine for the 16-bit × 16384-word NIOS/ARM shared on-chip RAM.
- Drives that RAM's second Avalon-MM slave port.
- Moves a block of consecutive words between the RAM and local valid/ready streams:
  - read direction: RAM to source stream;
  - write direction: sink stream to RAM.
- Sits beside the fluid-control logic, so firmware buffers can be bulk-loaded or drained without CPU copies.

Parameters:
- ADDR_W, 14, RAM word-address width.
- DATA_W, 16, RAM and stream data width.
- MAX_LEN, 16384, largest legal transfer length in words.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- dir  in  1  0 = RAM→stream (read), 1 = stream→RAM (write); sampled with start.
- base_addr  in  ADDR_W  first word address; sampled with start.
- length  in  ADDR_W+1  word count; sampled with start.
- abort  in  1  stop the current transfer.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 ok, 01 aborted, 10 bad length; valid with done, held until next start.
- m_address  out  ADDR_W  RAM address.
- m_byteenable  out  2  always 2'b11.
- m_chipselect  out  1  access strobe.
- m_write  out  1  write qualifier.
- m_writedata  out  DATA_W  write data.
- m_clken  out  1  tied 1 after reset.
- m_readdata  in  DATA_W  RAM read data.
- src_data  out  DATA_W  read stream data.
- src_valid  out  1  read stream valid.
- src_ready  in  1  read stream ready.
- snk_data  in  DATA_W  write stream data.
- snk_valid  in  1  write stream valid.
- snk_ready  out  1  write stream ready.

Behaviour:
- Reset values:
  - all outputs 0, except m_byteenable = 2'b11;
  - m_clken = 0 during reset, 1 after;
  - FSM in IDLE, FIFO empty.
- RAM timing:
  - A read presented in cycle t (m_chipselect=1, m_write=0) returns m_readdata in cycle t+1. The latency is fixed; the RAM has no waitrequest.
  - A write completes in the cycle it is presented.
- FSM states: IDLE, CHECK, READ, DRAIN, WRITE, FINISH.
- IDLE:
  - start latches dir, base_addr and length, then goes to CHECK.
  - start is ignored in every other state.
- CHECK:
  - length == 0 → FINISH, status ok, no RAM access.
  - length > MAX_LEN → FINISH, status 10, no RAM access.
  - otherwise → READ if dir=0, WRITE if dir=1.
- Address arithmetic:
  - address increments by 1 per issued access.
  - it wraps modulo 2^ADDR_W, so 16383 is followed by 0.
- READ:
  - Captured words go into a 2-entry FIFO that drives src_*.
  - A read is issued only when (fifo_count + inflight − pop_this_cycle) < 2.
  - This sustains 1 word/cycle while src_ready is held high.
  - src_valid = FIFO non-empty; a pop happens on src_valid & src_ready.
  - When the issue count is exhausted → DRAIN.
- DRAIN:
  - Wait until no read is in flight and the FIFO is empty → FINISH, status ok.
- WRITE:
  - snk_ready = 1 while the accept count is not zero.
  - Each accepted beat is registered and written in the following cycle (m_chipselect=1, m_write=1). Throughput is 1 word/cycle.
  - After the last write is issued → FINISH, status ok.
- abort in READ, DRAIN or WRITE:
  - No further issue or accept from the next cycle.
  - A read already in flight completes; its data is discarded.
  - The FIFO is flushed and src_valid drops.
  - A registered write beat already accepted is still written.
  - Then → FINISH, status 01.
  - abort in IDLE or CHECK has no effect.
- Simultaneous events:
  - abort in the same cycle as the last issue: the transfer still reports ok if all words were delivered; otherwise it reports 01.
- FINISH:
  - done = 1 for one cycle, busy falls in the same cycle, → IDLE.
  - start is accepted again from the next cycle.
- Asynchronous reset mid-transfer: everything returns to reset values immediately; no done pulse is generated.

Decomposition:
- Package fluid_board_soc_shared_mem_pkg:
  - state enum;
  - status codes STAT_OK, STAT_ABORT, STAT_BADLEN;
  - ADDR_W, DATA_W and MAX_LEN defaults.
- Sub-module fluid_board_soc_skid_fifo2: 2-entry valid/ready FIFO with flush, holding the read-return path.

Test Plan:
- RAM model preloaded with mem[i] = i ^ 16'hA5A5. Read with base 100, length 8, src_ready=1 → 8 beats, data mem[100..107], one per cycle. done at the first cycle with the FIFO empty after the last pop, status 00.
- Read with base 16380, length 6, src_ready toggling 1/0 → addresses 16380–16383 then 0–1. Never more than 2 words outstanding; data order preserved; no loss or duplication.
- Write with base 16383, length 3, snk_valid=1, data 1,2,3 → RAM[16383]=1, RAM[0]=2, RAM[1]=3. Exactly 3 write strobes, done with status 00.
- start with length=0 → done 2 cycles later, status 00, no m_chipselect. start with length=16385 → done, status 10, no m_chipselect.
- Read with length 20 and src_ready=0, abort asserted after 3 cycles → at most 2 reads issued. src_valid drops, done with status 01, then busy=0.
- reset_n asserted mid-write with length 10 → all outputs return to reset values immediately. After release, a new start with length 1 works normally.
